inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/inst_fetch.sv | 105 ++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared CPU constants for the instruction fetch slice.
// Default widths and depths used by the fetch stage and its buffers.
package inst_fetch_pkg;

  localparam int INST_ADDR_WIDTH_D = 16;
  localparam int INST_WIDTH_D      = 16;
  localparam int FETCH_DEPTH_D     = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for the address queue and output buffer.
// Empty FIFO presents zero on head so idle outputs read as zero.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULLC);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush drops everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset since empty masks head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: credit-limited requests, in-order buffer.
// Flush turns in-flight reads into drops counted down on return.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = INST_ADDR_WIDTH_D,
  parameter int INST_WIDTH      = INST_WIDTH_D,
  parameter int FETCH_DEPTH     = FETCH_DEPTH_D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_ADDR_WIDTH-1:0] pc_in,
  input  logic                       pc_valid,
  output logic                       pc_ready,
  input  logic                       flush,
  output logic                       mem_req,
  output logic [INST_ADDR_WIDTH-1:0] mem_addr,
  input  logic                       mem_rvalid,
  input  logic [INST_WIDTH-1:0]      mem_rdata,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr
);

  localparam int CW = cnt_w(FETCH_DEPTH);
  localparam int BW = INST_ADDR_WIDTH + INST_WIDTH;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FETCH_DEPTH);

  logic [CW-1:0]              aq_cnt;
  logic [CW-1:0]              ob_cnt;
  logic [CW-1:0]              drop_cnt;
  logic [CW:0]                used;
  logic [INST_ADDR_WIDTH-1:0] aq_head;
  logic [BW-1:0]              ob_head;
  logic                       aq_empty;
  logic                       aq_full;
  logic                       ob_empty;
  logic                       ob_full;
  logic                       accept;
  logic                       resp;
  logic                       keep;
  logic                       ob_pop;
  logic                       unused_full;

  assign used     = {1'b0, aq_cnt} + {1'b0, ob_cnt};
  assign pc_ready = !rst && !flush && (used < DEPTH_C);
  assign accept   = pc_valid && pc_ready;
  assign mem_req  = accept;
  assign mem_addr = pc_in;

  assign resp   = mem_rvalid && !aq_empty;
  assign keep   = resp && !flush && (drop_cnt == '0);
  assign ob_pop = inst_valid && inst_ready && !flush;

  assign inst_valid = !ob_empty;
  assign inst_addr  = ob_head[BW-1:INST_WIDTH];
  assign inst_out   = ob_head[INST_WIDTH-1:0];

  assign unused_full = aq_full | ob_full;

  fetch_fifo #(
    .WIDTH (INST_ADDR_WIDTH),
    .DEPTH (FETCH_DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (pc_in),
    .pop       (resp),
    .flush     (1'b0),
    .head      (aq_head),
    .full      (aq_full),
    .empty     (aq_empty),
    .count     (aq_cnt)
  );

  fetch_fifo #(
    .WIDTH (BW),
    .DEPTH (FETCH_DEPTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data ({aq_head, mem_rdata}),
    .pop       (ob_pop),
    .flush     (flush),
    .head      (ob_head),
    .full      (ob_full),
    .empty     (ob_empty),
    .count     (ob_cnt)
  );

  // Drop count: reloaded from in-flight reads on flush, else counts down.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= aq_cnt - CW'(resp);
    end else if (resp && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch.
// Epoch-tagged memory model predicts credits, drops and delivery.
module tb_inst_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst_out;
  logic [15:0] inst_addr;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          ep;
    int          born;
  } req_t;

  req_t        mq[$];
  logic [31:0] exp_q[$];
  int          nbuf = 0;
  int          epoch = 0;
  int          cyc_n = 0;
  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;

  inst_fetch #(
    .INST_ADDR_WIDTH (16),
    .INST_WIDTH      (16),
    .FETCH_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_addr  (inst_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", n, a, e, cyc_n);
    end
  endtask

  task automatic cyc(input bit pv, input logic [15:0] pc, input bit fl,
                     input bit rv, input bit ir, input logic [15:0] dat);
    bit rsp;
    bit rdy;
    bit acc;
    bit pop;
    @(posedge clk);
    #1;
    rsp = rv && (mq.size() > 0);
    if (rsp) rsp = (mq[0].born < cyc_n);
    pc_valid   = pv;
    pc_in      = pc;
    flush      = fl;
    inst_ready = ir && !fl;
    mem_rvalid = rsp;
    mem_rdata  = rsp ? mq[0].d : 16'($urandom);
    @(negedge clk);
    rdy = !fl && ((mq.size() + nbuf) < DEPTH);
    chk("pc_ready", pc_ready, rdy);
    chk("inst_valid", inst_valid, nbuf > 0);
    acc = pv && rdy;
    chk("mem_req", mem_req, acc);
    if (acc) chk("mem_addr", mem_addr, pc);
    pop = (nbuf > 0) && inst_ready;
    if (pop) nbuf--;
    if (rsp) begin
      if (!fl && mq[0].ep == epoch) nbuf++;
      void'(mq.pop_front());
    end
    if (fl) begin
      nbuf = 0;
      epoch++;
      exp_q.delete();
    end
    if (acc) begin
      mq.push_back('{pc, dat, epoch, cyc_n});
      exp_q.push_back({pc, dat});
    end
    cyc_n++;
  endtask

  task automatic idle(input bit rv, input bit ir);
    cyc(1'b0, 16'h0, 1'b0, rv, ir, 16'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    pc_valid = 1'b0;
    flush = 1'b0;
    mem_rvalid = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    chk("rst_pc_ready", pc_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    @(negedge clk);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_out", inst_out, 16'h0);
    chk("rst_inst_addr", inst_addr, 16'h0);
    chk("rst_pc_ready2", pc_ready, 1'b0);
    mq.delete();
    exp_q.delete();
    nbuf = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() > 0 || nbuf > 0) && n < 100) begin
      idle(1'b1, 1'b1);
      n++;
    end
    #1;
    chk("drain_timeout", n < 100, 1'b1);
    chk("drained", exp_q.size(), 0);
  endtask

  // Monitor: every consumed instruction must match the scoreboard head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst got=%h@%h exp=none",
                   inst_out, inst_addr);
        end else begin
          e = exp_q.pop_front();
          chk("inst_out", inst_out, e[15:0]);
          chk("inst_addr", inst_addr, e[31:16]);
          delivered++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    do_reset();

    d0 = delivered;
    cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'hA5A5);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    chk("a5_valid_pending", inst_valid, 1'b0);
    idle(1'b0, 1'b1);
    chk("a5_delivered", delivered - d0, 1);
    drain();

    do_reset();
    d0 = delivered;
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1000);
    cyc(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h1001);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h1002);
    cyc(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h1002);
    cyc(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h1002);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h1002);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h1002);
    drain();
    chk("b2b_delivered", delivered - d0, 3);

    do_reset();
    d0 = delivered;
    cyc(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h2020);
    cyc(1'b1, 16'h0021, 1'b0, 1'b0, 1'b0, 16'h2021);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("flush_valid", inst_valid, 1'b0);
    cyc(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h4040);
    drain();
    chk("flush_delivered", delivered - d0, 1);

    do_reset();
    d0 = delivered;
    cyc(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0, 16'h5050);
    idle(1'b1, 1'b0);
    cyc(1'b1, 16'h0051, 1'b0, 1'b0, 1'b0, 16'h5051);
    idle(1'b1, 1'b1);
    chk("simul_valid", inst_valid, 1'b1);
    drain();
    chk("simul_delivered", delivered - d0, 2);

    cyc(1'b1, 16'h0060, 1'b0, 1'b0, 1'b0, 16'h6060);
    idle(1'b1, 1'b0);
    cyc(1'b1, 16'h0061, 1'b0, 1'b0, 1'b0, 16'h6061);
    do_reset();
    idle(1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 3) != 0, 16'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) != 0, 16'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
